// File: rtl/vec_pair_packer.sv
// vec_pair_packer: gathers a serial element stream into two packed vectors
// (A, then B) and hands the pair to the dot-product unit over valid/ready.
// A short vector is ended early with elem_last. Lanes it does not reach stay
// zero, because the vector registers are cleared on reset and after every
// handoff, so those lanes add nothing to the product.
module vec_pair_packer #(
   parameter int NUM_ELEMS = 4,
   parameter int ELEM_W    = 32,
   localparam int VEC_W    = NUM_ELEMS * ELEM_W,
   localparam int CNT_W    = $clog2(NUM_ELEMS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              elem_valid,
   input  logic [ELEM_W-1:0] elem_data,
   input  logic              elem_last,
   output logic              elem_ready,
   output logic [VEC_W-1:0]  vec_a,
   output logic [VEC_W-1:0]  vec_b,
   output logic [CNT_W-1:0]  len_a,
   output logic [CNT_W-1:0]  len_b,
   output logic              vec_valid,
   input  logic              vec_ready
);

   localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

   typedef enum logic [1:0] {
      FILL_A = 2'd0,
      FILL_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               accept;
   logic               handoff;
   logic               lane_last;
   logic [CNT_W-1:0]   len_next;

   // Writes one element into the selected lane and leaves the other lanes untouched.
   function automatic logic [VEC_W-1:0] put_lane(input logic [VEC_W-1:0]  vec,
                                                 input logic [IDX_W-1:0]  lane,
                                                 input logic [ELEM_W-1:0] data);
      logic [VEC_W-1:0] res;
      res = vec;
      for (int i = 0; i < NUM_ELEMS; i++) begin
         if (lane == IDX_W'(i)) begin
            res[i*ELEM_W +: ELEM_W] = data;
         end
      end
      return res;
   endfunction

   // Elements are taken only while filling. Reset blocks every handshake.
   assign elem_ready = !rst && (state != HOLD);
   assign accept     = elem_valid && elem_ready;
   assign handoff    = vec_valid && vec_ready && !rst;
   // The last lane ends a vector whether or not elem_last is set.
   assign lane_last  = elem_last || (idx == IDX_W'(NUM_ELEMS - 1));
   assign len_next   = CNT_W'(idx) + CNT_W'(1);

   // Fill/hold sequencer with registered vectors, lengths and vec_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL_A;
         idx       <= '0;
         vec_a     <= '0;
         vec_b     <= '0;
         len_a     <= '0;
         len_b     <= '0;
         vec_valid <= 1'b0;
      end else begin
         case (state)
            FILL_A: begin
               if (accept) begin
                  vec_a <= put_lane(vec_a, idx, elem_data);
                  if (lane_last) begin
                     len_a <= len_next;
                     idx   <= '0;
                     state <= FILL_B;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            FILL_B: begin
               if (accept) begin
                  vec_b <= put_lane(vec_b, idx, elem_data);
                  if (lane_last) begin
                     len_b     <= len_next;
                     idx       <= '0;
                     state     <= HOLD;
                     vec_valid <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (handoff) begin
                  vec_a     <= '0;
                  vec_b     <= '0;
                  len_a     <= '0;
                  len_b     <= '0;
                  idx       <= '0;
                  vec_valid <= 1'b0;
                  state     <= FILL_A;
               end
            end
            default: begin
               state     <= FILL_A;
               idx       <= '0;
               vec_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_pair_packer.sv
// Directed bench for vec_pair_packer: a table of per-cycle records
// (inputs plus expected outputs seen during that cycle), followed by
// hand-written backpressure and reset sequences.
module tb_vec_pair_packer;

   localparam int NUM_ELEMS = 4;
   localparam int ELEM_W    = 32;
   localparam int VEC_W     = NUM_ELEMS * ELEM_W;
   localparam int CNT_W     = $clog2(NUM_ELEMS + 1);
   localparam logic [VEC_W-1:0] Z = '0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              elem_valid = 1'b0;
   logic [ELEM_W-1:0] elem_data = '0;
   logic              elem_last = 1'b0;
   logic              elem_ready;
   logic [VEC_W-1:0]  vec_a;
   logic [VEC_W-1:0]  vec_b;
   logic [CNT_W-1:0]  len_a;
   logic [CNT_W-1:0]  len_b;
   logic              vec_valid;
   logic              vec_ready = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   vec_pair_packer #(.NUM_ELEMS(NUM_ELEMS), .ELEM_W(ELEM_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .elem_valid (elem_valid),
      .elem_data  (elem_data),
      .elem_last  (elem_last),
      .elem_ready (elem_ready),
      .vec_a      (vec_a),
      .vec_b      (vec_b),
      .len_a      (len_a),
      .len_b      (len_b),
      .vec_valid  (vec_valid),
      .vec_ready  (vec_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string              name;
      bit                 chk;
      bit                 rs;
      bit                 v;
      logic [ELEM_W-1:0]  d;
      bit                 l;
      bit                 vr;
      bit                 er;
      bit                 vv;
      logic [VEC_W-1:0]   a;
      logic [VEC_W-1:0]   b;
      logic [CNT_W-1:0]   la;
      logic [CNT_W-1:0]   lb;
      longint             dot;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [VEC_W-1:0] P(input int x0, input int x1, input int x2, input int x3);
      return {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
   endfunction

   function automatic vec_t mk(input string nm, input bit rs, input bit v, input int d, input bit l,
                               input bit vr, input bit er, input bit vv,
                               input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                               input int la, input int lb, input longint dot);
      vec_t r;
      r.name = nm; r.chk = 1'b1; r.rs = rs; r.v = v; r.d = 32'(d); r.l = l; r.vr = vr;
      r.er = er; r.vv = vv; r.a = a; r.b = b; r.la = CNT_W'(la); r.lb = CNT_W'(lb); r.dot = dot;
      return r;
   endfunction

   // Drive one cycle of inputs after the falling edge, check outputs 1ns later.
   task automatic step(input vec_t r);
      longint dot;
      bit     ok;
      @(negedge clk);
      rst = r.rs; elem_valid = r.v; elem_data = r.d; elem_last = r.l; vec_ready = r.vr;
      #1;
      if (r.chk) begin
         n_vec++;
         dot = 0;
         for (int i = 0; i < NUM_ELEMS; i++)
            dot += longint'($signed(vec_a[i*ELEM_W +: ELEM_W])) * longint'($signed(vec_b[i*ELEM_W +: ELEM_W]));
         ok = (elem_ready === r.er) && (vec_valid === r.vv) && (vec_a === r.a) && (vec_b === r.b) &&
              (len_a === r.la) && (len_b === r.lb);
         if (r.vv && dot != r.dot) ok = 1'b0;
         if (!ok) begin
            n_err++;
            $display("FAIL %s: got er=%b vv=%b a=%h b=%h la=%0d lb=%0d dot=%0d, want er=%b vv=%b a=%h b=%h la=%0d lb=%0d dot=%0d",
                     r.name, elem_ready, vec_valid, vec_a, vec_b, len_a, len_b, dot,
                     r.er, r.vv, r.a, r.b, r.la, r.lb, r.dot);
         end
      end
   endtask

   task automatic row(input string nm, input bit rs, input bit v, input int d, input bit l, input bit vr,
                      input bit er, input bit vv, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                      input int la, input int lb, input longint dot);
      tbl.push_back(mk(nm, rs, v, d, l, vr, er, vv, a, b, la, lb, dot));
   endtask

   task automatic cyc(input string nm, input bit rs, input bit v, input int d, input bit l, input bit vr,
                      input bit er, input bit vv, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                      input int la, input int lb, input longint dot);
      step(mk(nm, rs, v, d, l, vr, er, vv, a, b, la, lb, dot));
   endtask

   // Unchecked element offer, used to build up state for the hand sequences.
   task automatic feed(input int d, input bit vr);
      vec_t r;
      r = mk("feed", 1'b0, 1'b1, d, 1'b0, vr, 1'b0, 1'b0, Z, Z, 0, 0, 0);
      r.chk = 1'b0;
      step(r);
   endtask

   initial begin
      // reset state
      row("reset",  1, 0, 0, 0, 1,  0, 0, Z, Z, 0, 0, 0);
      // full pair 1..4 / 5..8
      row("full0",  0, 1, 1, 0, 1,  1, 0, Z, Z, 0, 0, 0);
      row("full1",  0, 1, 2, 0, 1,  1, 0, P(1,0,0,0), Z, 0, 0, 0);
      row("full2",  0, 1, 3, 0, 1,  1, 0, P(1,2,0,0), Z, 0, 0, 0);
      row("full3",  0, 1, 4, 0, 1,  1, 0, P(1,2,3,0), Z, 0, 0, 0);
      row("full4",  0, 1, 5, 0, 1,  1, 0, P(1,2,3,4), Z, 4, 0, 0);
      row("full5",  0, 1, 6, 0, 1,  1, 0, P(1,2,3,4), P(5,0,0,0), 4, 0, 0);
      row("full6",  0, 1, 7, 0, 1,  1, 0, P(1,2,3,4), P(5,6,0,0), 4, 0, 0);
      row("full7",  0, 1, 8, 0, 1,  1, 0, P(1,2,3,4), P(5,6,7,0), 4, 0, 0);
      row("full_hold", 0, 0, 0, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      row("full_clr",  0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);
      // short vectors A = 7,9  B = 3
      row("short0", 0, 1, 7, 0, 1,  1, 0, Z, Z, 0, 0, 0);
      row("short1", 0, 1, 9, 1, 1,  1, 0, P(7,0,0,0), Z, 0, 0, 0);
      row("short2", 0, 1, 3, 1, 1,  1, 0, P(7,9,0,0), Z, 2, 0, 0);
      row("short_hold", 0, 0, 0, 0, 1, 0, 1, P(7,9,0,0), P(3,0,0,0), 2, 1, 21);
      row("short_clr",  0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);
      // bubbles between elements; junk data/last while idle; redundant last on lane 3
      row("bub0",  0, 1, 1, 0, 1,  1, 0, Z, Z, 0, 0, 0);
      row("bub1",  0, 0, 32'hdead, 1, 1, 1, 0, P(1,0,0,0), Z, 0, 0, 0);
      row("bub2",  0, 1, 2, 0, 1,  1, 0, P(1,0,0,0), Z, 0, 0, 0);
      row("bub3",  0, 0, 32'hbeef, 1, 1, 1, 0, P(1,2,0,0), Z, 0, 0, 0);
      row("bub4",  0, 1, 3, 0, 1,  1, 0, P(1,2,0,0), Z, 0, 0, 0);
      row("bub5",  0, 0, 77, 1, 1, 1, 0, P(1,2,3,0), Z, 0, 0, 0);
      row("bub6",  0, 1, 4, 1, 1,  1, 0, P(1,2,3,0), Z, 0, 0, 0);
      row("bub7",  0, 0, 0, 0, 1,  1, 0, P(1,2,3,4), Z, 4, 0, 0);
      row("bub8",  0, 1, 5, 0, 1,  1, 0, P(1,2,3,4), Z, 4, 0, 0);
      row("bub9",  0, 0, 66, 1, 1, 1, 0, P(1,2,3,4), P(5,0,0,0), 4, 0, 0);
      row("bub10", 0, 1, 6, 0, 1,  1, 0, P(1,2,3,4), P(5,0,0,0), 4, 0, 0);
      row("bub11", 0, 0, 0, 0, 1,  1, 0, P(1,2,3,4), P(5,6,0,0), 4, 0, 0);
      row("bub12", 0, 1, 7, 0, 1,  1, 0, P(1,2,3,4), P(5,6,0,0), 4, 0, 0);
      row("bub13", 0, 0, 0, 1, 1,  1, 0, P(1,2,3,4), P(5,6,7,0), 4, 0, 0);
      row("bub14", 0, 1, 8, 0, 1,  1, 0, P(1,2,3,4), P(5,6,7,0), 4, 0, 0);
      row("bub_hold", 0, 0, 0, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      row("bub_clr",  0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);
      // back-to-back pairs, elem_valid and vec_ready held high
      row("b2b0",  0, 1, 1, 0, 1,  1, 0, Z, Z, 0, 0, 0);
      row("b2b1",  0, 1, 2, 0, 1,  1, 0, P(1,0,0,0), Z, 0, 0, 0);
      row("b2b2",  0, 1, 3, 0, 1,  1, 0, P(1,2,0,0), Z, 0, 0, 0);
      row("b2b3",  0, 1, 4, 0, 1,  1, 0, P(1,2,3,0), Z, 0, 0, 0);
      row("b2b4",  0, 1, 5, 0, 1,  1, 0, P(1,2,3,4), Z, 4, 0, 0);
      row("b2b5",  0, 1, 6, 0, 1,  1, 0, P(1,2,3,4), P(5,0,0,0), 4, 0, 0);
      row("b2b6",  0, 1, 7, 0, 1,  1, 0, P(1,2,3,4), P(5,6,0,0), 4, 0, 0);
      row("b2b7",  0, 1, 8, 0, 1,  1, 0, P(1,2,3,4), P(5,6,7,0), 4, 0, 0);
      row("b2b_hold1", 0, 1, 9, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      row("b2b9",  0, 1, 9, 0, 1,  1, 0, Z, Z, 0, 0, 0);
      row("b2b10", 0, 1, 10, 0, 1, 1, 0, P(9,0,0,0), Z, 0, 0, 0);
      row("b2b11", 0, 1, 11, 0, 1, 1, 0, P(9,10,0,0), Z, 0, 0, 0);
      row("b2b12", 0, 1, 12, 0, 1, 1, 0, P(9,10,11,0), Z, 0, 0, 0);
      row("b2b13", 0, 1, 13, 0, 1, 1, 0, P(9,10,11,12), Z, 4, 0, 0);
      row("b2b14", 0, 1, 14, 0, 1, 1, 0, P(9,10,11,12), P(13,0,0,0), 4, 0, 0);
      row("b2b15", 0, 1, 15, 0, 1, 1, 0, P(9,10,11,12), P(13,14,0,0), 4, 0, 0);
      row("b2b16", 0, 1, 16, 0, 1, 1, 0, P(9,10,11,12), P(13,14,15,0), 4, 0, 0);
      row("b2b_hold2", 0, 1, 17, 0, 1, 0, 1, P(9,10,11,12), P(13,14,15,16), 4, 4, 614);
      row("b2b_clr", 0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // backpressure: 5 stalled cycles with an element on offer, then handoff
      for (int k = 1; k <= 8; k++) feed(k, 1'b0);
      for (int s = 0; s < 5; s++)
         cyc("stall", 0, 1, 99, 0, 0, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      cyc("stall_release", 0, 1, 99, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      cyc("after_handoff", 0, 1, 99, 0, 0, 1, 0, Z, Z, 0, 0, 0);
      cyc("stall_elem_once", 0, 0, 0, 0, 0, 1, 0, P(99,0,0,0), Z, 0, 0, 0);
      cyc("rst_partial", 1, 0, 0, 0, 0, 0, 0, P(99,0,0,0), Z, 0, 0, 0);
      cyc("rst_partial_clr", 0, 0, 0, 0, 0, 1, 0, Z, Z, 0, 0, 0);

      // reset after two A elements
      feed(1, 1'b1);
      feed(2, 1'b1);
      cyc("rst_fill", 1, 1, 50, 0, 1, 0, 0, P(1,2,0,0), Z, 0, 0, 0);
      cyc("rst_fill_clr", 0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);

      // reset during HOLD with vec_ready high: no handoff, everything cleared
      for (int k = 1; k <= 8; k++) feed(k, 1'b0);
      cyc("pre_rst_hold", 0, 0, 0, 0, 0, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      cyc("rst_hold", 1, 1, 60, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      cyc("rst_hold_clr", 0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);

      // a fresh stream after reset gives the plain full-pair result
      for (int k = 1; k <= 8; k++) feed(k, 1'b1);
      cyc("post_rst_hold", 0, 0, 0, 0, 1, 0, 1, P(1,2,3,4), P(5,6,7,8), 4, 4, 70);
      cyc("post_rst_clr", 0, 0, 0, 0, 1, 1, 0, Z, Z, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vec_pair_packer.md
Name: vec_pair_packer

Overview:
- Producer-side front end for the 4-lane dot-product unit.
- Collects a serial stream of 32-bit elements into two packed vectors, A first and then B.
- Presents the packed pair with a valid/ready handshake to the downstream consumer. Its vec_a/vec_b outputs drive the dot-product inputs directly.
- Supports short vectors: an early last-element marker ends the current vector and zero-pads the remaining lanes, which contribute 0 to the product.

Parameters:
- NUM_ELEMS, 4: lanes per vector.
- ELEM_W, 32: bits per element.
- VEC_W, NUM_ELEMS*ELEM_W: packed vector width (derived, not overridden).
- CNT_W, $clog2(NUM_ELEMS+1): width of the length outputs.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- elem_valid  input  1  upstream element valid.
- elem_data  input  ELEM_W  element value.
- elem_last  input  1  marks the final element of the current vector (A or B).
- elem_ready  output  1  block accepts an element this cycle.
- vec_a  output  VEC_W  packed vector A; element i at [ELEM_W*i +: ELEM_W].
- vec_b  output  VEC_W  packed vector B, same lane layout.
- len_a  output  CNT_W  count of elements actually written into A (1..NUM_ELEMS).
- len_b  output  CNT_W  count of elements actually written into B.
- vec_valid  output  1  packed pair available.
- vec_ready  input  1  downstream consumes the pair.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- **Reset** (rst high at a clk edge): state=FILL_A, lane index=0, vec_a=vec_b=0, len_a=len_b=0, vec_valid=0.
  - elem_ready is 0 in any cycle where rst is high.
  - Reset mid-fill or mid-hold discards all partial or pending data. No handshake completes in a cycle where rst is high.
- **Element accept:** an element is accepted when elem_valid & elem_ready at a clk edge.
- **Packed-pair handoff:** occurs when vec_valid & vec_ready at a clk edge.
- **State FILL_A** (elem_ready=1, vec_valid=0):
  - On accept, write elem_data into vec_a lane idx.
  - If idx==NUM_ELEMS-1 or elem_last=1: len_a<=idx+1, idx<=0, go to FILL_B.
  - Otherwise idx<=idx+1.
- **State FILL_B:** identical to FILL_A but writes vec_b/len_b. On completion go to HOLD.
- **State HOLD** (elem_ready=0, vec_valid=1):
  - vec_a, vec_b, len_a, len_b are stable and unchanged.
  - On handoff: clear vec_a, vec_b, len_a, len_b to 0, idx<=0, go to FILL_A.
- **Latency:** vec_valid rises the cycle after the edge that accepts the final B element. Minimum pair period is 2*NUM_ELEMS+1 cycles for full vectors.
- **No overlap:** elements are never accepted in HOLD. Handoff and element accept never coincide.
- **Zero padding:**
  - Lanes not written in a fill remain 0 because registers are cleared on reset and on handoff.
  - elem_last on lane NUM_ELEMS-1 is redundant and behaves the same as elem_last=0.
- **elem_data/elem_last** are don't-care when elem_valid=0. elem_valid may toggle freely; idle cycles in FILL states hold all state.
- **vec_ready** may be held high continuously. It is ignored outside HOLD.
- No arithmetic beyond the idx increment. idx never exceeds NUM_ELEMS-1 (no wrap past lane 3 at defaults).
- Outputs vec_a, vec_b, len_a, len_b, vec_valid are registered. elem_ready is a combinational decode of state and rst.

Test Plan:
1. Full pair: stream 1,2,3,4 then 5,6,7,8 with elem_valid held high and vec_ready=1 -> vec_valid high on cycle 9 after the first accept.
   - vec_a lanes = {1,2,3,4}, vec_b lanes = {5,6,7,8}, len_a=len_b=4.
   - Downstream dot result = 70.
   - FILL_A resumes the next cycle with all outputs cleared.
2. Short vectors: A = 7,9 (elem_last on 9); B = 3 (elem_last on 3) -> vec_a = {7,9,0,0}, vec_b = {3,0,0,0}, len_a=2, len_b=1.
3. Backpressure: complete a pair with vec_ready=0 for 5 cycles -> vec_valid stays 1, outputs constant, elem_ready=0.
   - Elements offered during the stall are not consumed.
   - Raising vec_ready completes the handoff in 1 cycle.
4. Bubbles: insert elem_valid=0 gaps between every element -> same packed result as scenario 1. idx advances only on accepts.
5. Reset mid-operation: assert rst after 2 A elements, and separately during HOLD -> next cycle all outputs are 0 and elem_ready=1 after rst falls.
   - The next stream 1..8 produces exactly the scenario-1 result.
6. Back-to-back pairs: vec_ready tied high, 16 consecutive elements 1..16 -> two handoffs.
   - Second pair is A = {9..12}, B = {13..16}, lengths 4.
   - No element lost or duplicated.
